// File: rtl/walk_port_arbiter_pkg.sv
// Shared types and constants for the page-table-walk port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int unsigned ARB_LOCK_MAX_DEFAULT = 64;

  // Index arithmetic modulo the requester count.
  function automatic int unsigned rr_wrap_add(input int unsigned a, input int unsigned b,
                                              input int unsigned n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/walk_port_arbiter_if.sv
// Requester-side and memory-side walk-port signals of the arbiter.
interface walk_port_arbiter_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) ();

  logic [N_REQ-1:0]        req_ren;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_stall;
  logic [DATA_W-1:0]       req_rdata;
  logic                    mem_ren;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    mem_rvalid;

  // Environment side: MMUs plus the shared memory port.
  modport master (
    output req_ren, req_addr, mem_rdata, mem_rvalid,
    input  req_stall, req_rdata, mem_ren, mem_addr
  );

  // Arbiter side.
  modport slave (
    input  req_ren, req_addr, mem_rdata, mem_rvalid,
    output req_stall, req_rdata, mem_ren, mem_addr
  );

endinterface

// File: rtl/walk_port_arbiter_rr_picker.sv
// Stateless round-robin picker: first requester at or after ptr wins.
module rr_picker
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     gnt_valid
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  int unsigned j;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = rr_wrap_add(32'(ptr), k, N_REQ);
      if (!gnt_valid && req[IDX_W'(j)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/walk_port_arbiter.sv
// Locks the shared PTE read port to one MMU for a whole walk, round-robin between walks.
// Optional lock timeout enabled by defining ARB_LOCK_TIMEOUT_EN.
module walk_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned LOCK_MAX = ARB_LOCK_MAX_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  walk_port_arbiter_if.slave       bus,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     lock_timeout
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || LOCK_MAX < 2) begin : g_bad_param
    $error("walk_port_arbiter: N_REQ must be 2..8 and LOCK_MAX at least 2");
  end

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              timeout_q, timeout_d;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_valid;
  logic              own_ren;
  logic              lock_expired;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req       (bus.req_ren),
    .ptr       (rr_ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign own_ren      = bus.req_ren[owner_q];
  assign bus.mem_ren  = (state_q == REQ) && own_ren;
  assign bus.mem_addr = bus.req_addr[int'(owner_q)*ADDR_W +: ADDR_W];

  // Only the owner, and only in its RESP bubble, sees stall drop.
  for (genvar i = 0; i < N_REQ; i++) begin : g_stall
    assign bus.req_stall[i] = bus.req_ren[i] & ~((state_q == RESP) && (owner_q == IDX_W'(i)));
  end

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Lock age: zero while idle (so zero at grant), saturating while locked.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign lock_expired = (cnt_q >= CNT_W'(LOCK_MAX - 1));
`else
  assign lock_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    rdata_d   = rdata_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d  = gnt_idx;
          rr_ptr_d = IDX_W'(rr_wrap_add(32'(gnt_idx), 1, N_REQ));
          state_d  = REQ;
        end
      end
      REQ: begin
        if (!own_ren) begin
          state_d = IDLE;
        end else if (bus.mem_rvalid) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (lock_expired) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides everything; pointer and read data are preserved.
    if (flush) begin
      state_d   = IDLE;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      rdata_d   = rdata_q;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign owner         = owner_q;
  assign busy          = (state_q != IDLE);
  assign lock_timeout  = timeout_q;
  assign bus.req_rdata = rdata_q;

endmodule

// File: tb/tb_walk_port_arbiter.sv
// Directed bench for walk_port_arbiter with hand-computed cycle-by-cycle expectations.
module tb_walk_port_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int unsigned TB_LOCK_MAX = 8;
  localparam int          WALK_L      = 0;
`else
  localparam int unsigned TB_LOCK_MAX = 64;
  localparam int          WALK_L      = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic owner;
  logic busy;
  logic lock_timeout;

  walk_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  walk_port_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(TB_LOCK_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .owner        (owner),
    .busy         (busy),
    .lock_timeout (lock_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are driven at +1 after the edge and outputs checked at +2.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_addr(input int r, input logic [63:0] a);
    bus.req_addr[r*64 +: 64] = a;
  endtask

  // One PTE access by owner r, entered at the first REQ cycle; returns in RESP.
  task automatic do_level(input int r, input logic [63:0] a, input int lat, input logic [63:0] d);
    for (int i = 0; i < lat; i++) begin
      bus.mem_rvalid = 1'b0;
      settle();
      check_eq("wait_mem_ren", 64'(bus.mem_ren), 64'(1));
      check_eq("wait_mem_addr", bus.mem_addr, a);
      check_eq("wait_owner", 64'(owner), 64'(r));
      check_eq("wait_stall", 64'(bus.req_stall[r]), 64'(1));
      cyc();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = d;
    settle();
    check_eq("rv_mem_ren", 64'(bus.mem_ren), 64'(1));
    check_eq("rv_mem_addr", bus.mem_addr, a);
    check_eq("rv_owner", 64'(owner), 64'(r));
    cyc();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    settle();
    check_eq("resp_mem_ren", 64'(bus.mem_ren), 64'(0));
    check_eq("resp_stall_own", 64'(bus.req_stall[r]), 64'(0));
    check_eq("resp_stall_other", 64'(bus.req_stall[1-r]), 64'(bus.req_ren[1-r]));
    check_eq("resp_rdata", bus.req_rdata, d);
    check_eq("resp_busy", 64'(busy), 64'(1));
    check_eq("resp_timeout", 64'(lock_timeout), 64'(0));
  endtask

  // Single-level walk by r, then drop ren and optionally re-raise it in the IDLE cycle.
  task automatic walk1(input int r, input logic [63:0] a, input int lat, input logic [63:0] d,
                       input logic keep);
    do_level(r, a, lat, d);
    cyc();
    bus.req_ren[r] = 1'b0;
    settle();
    check_eq("drop_mem_ren", 64'(bus.mem_ren), 64'(0));
    check_eq("drop_stall_own", 64'(bus.req_stall[r]), 64'(0));
    check_eq("drop_stall_other", 64'(bus.req_stall[1-r]), 64'(1));
    cyc();
    bus.req_ren[r] = keep;
    settle();
    check_eq("handover_busy", 64'(busy), 64'(0));
    check_eq("handover_stall_other", 64'(bus.req_stall[1-r]), 64'(1));
    cyc();
  endtask

  initial begin
    bus.req_ren    = '0;
    bus.req_addr   = '0;
    bus.mem_rdata  = '0;
    bus.mem_rvalid = 1'b0;

    // Reset values
    cyc();
    cyc();
    bus.req_ren = 2'b10;
    settle();
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_owner", 64'(owner), 64'(0));
    check_eq("rst_rdata", bus.req_rdata, 64'(0));
    check_eq("rst_mem_ren", 64'(bus.mem_ren), 64'(0));
    check_eq("rst_timeout", 64'(lock_timeout), 64'(0));
    check_eq("rst_stall", 64'(bus.req_stall), 64'(2'b10));
    bus.req_ren = '0;
    rst = 1'b1;
    cyc();

    // Three-level walk by requester 0
    set_addr(0, 64'h1000);
    bus.req_ren[0] = 1'b1;
    settle();
    check_eq("walk_idle_busy", 64'(busy), 64'(0));
    check_eq("walk_idle_mem_ren", 64'(bus.mem_ren), 64'(0));
    check_eq("walk_idle_stall", 64'(bus.req_stall[0]), 64'(1));
    cyc();
    do_level(0, 64'h1000, WALK_L, 64'h11);
    set_addr(0, 64'h2000);
    cyc();
    do_level(0, 64'h2000, WALK_L, 64'h22);
    set_addr(0, 64'h3000);
    cyc();
    do_level(0, 64'h3000, WALK_L, 64'h33);
    cyc();
    bus.req_ren[0] = 1'b0;
    settle();
    check_eq("walk_end_mem_ren", 64'(bus.mem_ren), 64'(0));
    check_eq("walk_end_busy", 64'(busy), 64'(1));
    cyc();
    settle();
    check_eq("walk_idle_after", 64'(busy), 64'(0));
    check_eq("walk_rdata_hold", bus.req_rdata, 64'h33);

    // Contention from reset, then round-robin 0,1,0,1 (and 0 again)
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    set_addr(0, 64'hA000);
    set_addr(1, 64'hB000);
    bus.req_ren = 2'b11;
    settle();
    check_eq("cont_idle_stall", 64'(bus.req_stall), 64'(2'b11));
    cyc();
    walk1(0, 64'hA000, 1, 64'h44, 1'b1);
    walk1(1, 64'hB000, 1, 64'h55, 1'b1);
    walk1(0, 64'hA000, 2, 64'h66, 1'b1);
    walk1(1, 64'hB000, 0, 64'h77, 1'b0);
    bus.req_ren = '0;
    settle();
    check_eq("rr_fifth_owner", 64'(owner), 64'(0));
    check_eq("rr_fifth_busy", 64'(busy), 64'(1));
    cyc();

    // Flush while waiting for the response
    set_addr(0, 64'hC000);
    bus.req_ren[0] = 1'b1;
    cyc();
    settle();
    check_eq("fl_req_mem_ren", 64'(bus.mem_ren), 64'(1));
    cyc();
    flush = 1'b1;
    settle();
    check_eq("fl_cycle_mem_ren", 64'(bus.mem_ren), 64'(1));
    cyc();
    flush = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hDEAD;
    settle();
    check_eq("fl_idle_busy", 64'(busy), 64'(0));
    check_eq("fl_idle_mem_ren", 64'(bus.mem_ren), 64'(0));
    check_eq("fl_idle_rdata", bus.req_rdata, 64'h77);
    cyc();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    settle();
    check_eq("fl_late_rdata", bus.req_rdata, 64'h77);
    check_eq("fl_regrant_busy", 64'(busy), 64'(1));
    check_eq("fl_regrant_owner", 64'(owner), 64'(0));
    bus.req_ren = '0;
    cyc();

    // Reset during RESP; a fresh grant restarts from requester 0
    set_addr(0, 64'hD000);
    set_addr(1, 64'hD800);
    bus.req_ren[0] = 1'b1;
    cyc();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h88;
    settle();
    check_eq("mr_mem_ren", 64'(bus.mem_ren), 64'(1));
    cyc();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    settle();
    check_eq("mr_resp_stall", 64'(bus.req_stall[0]), 64'(0));
    check_eq("mr_resp_rdata", bus.req_rdata, 64'h88);
    rst = 1'b0;
    bus.req_ren[1] = 1'b1;
    cyc();
    rst = 1'b1;
    settle();
    check_eq("mr_busy", 64'(busy), 64'(0));
    check_eq("mr_owner", 64'(owner), 64'(0));
    check_eq("mr_rdata", bus.req_rdata, 64'(0));
    check_eq("mr_mem_ren_rst", 64'(bus.mem_ren), 64'(0));
    check_eq("mr_timeout", 64'(lock_timeout), 64'(0));
    check_eq("mr_stall", 64'(bus.req_stall), 64'(2'b11));
    cyc();
    settle();
    check_eq("mr_regrant_owner", 64'(owner), 64'(0));
    check_eq("mr_regrant_addr", bus.mem_addr, 64'hD000);
    check_eq("mr_regrant_ren", 64'(bus.mem_ren), 64'(1));
    bus.req_ren = '0;
    cyc();
    settle();
    check_eq("mr_end_busy", 64'(busy), 64'(0));

`ifdef ARB_LOCK_TIMEOUT_EN
    // Lock timeout: requester 0 never releases, requester 1 waits
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    set_addr(0, 64'hE000);
    set_addr(1, 64'hF000);
    bus.req_ren = 2'b11;
    cyc();
    do_level(0, 64'hE000, 1, 64'h91);
    cyc();
    do_level(0, 64'hE000, 1, 64'h92);
    cyc();
    do_level(0, 64'hE000, 1, 64'h93);
    cyc();
    settle();
    check_eq("to_busy", 64'(busy), 64'(0));
    check_eq("to_pulse", 64'(lock_timeout), 64'(1));
    check_eq("to_stall_waiter", 64'(bus.req_stall[1]), 64'(1));
    cyc();
    settle();
    check_eq("to_pulse_end", 64'(lock_timeout), 64'(0));
    check_eq("to_new_owner", 64'(owner), 64'(1));
    check_eq("to_new_addr", bus.mem_addr, 64'hF000);
    bus.req_ren = '0;
    cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/walk_port_arbiter.md
# walk_port_arbiter

Arbitrates one memory read port among `N_REQ` page-table-walk requesters, such as the instruction-side and data-side MMUs, each using the `ren`/`addr`/`rdata`/`mmu_stall` walk protocol. A grant is locked to one requester for its whole multi-level walk, so the PTE reads of one walk never interleave with another's. Grants between walks rotate round-robin. The block sits between the MMU instances and the shared memory/cache read port.

## Interface
- `N_REQ`, default 2: number of requesters (2..8).
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: PTE/data width.
- `LOCK_MAX`, default 64: lock timeout in cycles; used only with `ARB_LOCK_TIMEOUT_EN`.

Ports (reset `rst`, synchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-low reset
- `flush`  in  1  abort current access and release lock
- `req_ren`  in  N_REQ  per-requester read request; held high for the whole walk
- `req_addr`  in  N_REQ*ADDR_W  per-requester PTE address; slice i = `[i*ADDR_W +: ADDR_W]`
- `req_stall`  out  N_REQ  per-requester stall (the MMU's `mmu_stall`)
- `req_rdata`  out  DATA_W  registered read data, broadcast to all requesters
- `mem_ren`  out  1  memory read request
- `mem_addr`  out  ADDR_W  memory read address
- `mem_rdata`  in  DATA_W  memory read data
- `mem_rvalid`  in  1  `mem_rdata` valid
- `owner`  out  $clog2(N_REQ)  current/last grant index
- `busy`  out  1  lock held (state != IDLE)
- `lock_timeout`  out  1  one-cycle pulse on forced release

## Operation
- **States** (`arb_state_t`): IDLE, REQ, RESP.
- **IDLE**
  - If any `req_ren` bit is set, the round-robin picker selects a winner, starting from `rr_ptr`.
  - `owner` <= winner; `rr_ptr` <= winner+1 (mod N_REQ); go to REQ.
  - With no request, stay in IDLE.
- **REQ**
  - `mem_ren = req_ren[owner]` and `mem_addr = req_addr[owner]` (combinational).
  - If `req_ren[owner]`=0: release and go to IDLE; no read is issued.
  - If `mem_ren & mem_rvalid`: `req_rdata` <= `mem_rdata`; go to RESP.
  - Otherwise stay in REQ.
- **RESP**
  - `mem_ren`=0. The owner sees stall low this cycle and samples `req_rdata`.
  - Go to REQ unconditionally. The owner either updates its address for the next level or drops `req_ren`, which releases the lock in REQ.
- **Stall rule:** `req_stall[i] = req_ren[i] & !(state==RESP & owner==i)`. A requester with `req_ren`=0 is never stalled.
- **flush:** has priority over every state transition. Next state is IDLE, `mem_ren` is 0 from the next cycle, `rr_ptr` is unchanged, and `req_rdata` holds its value.
- **Memory contract:** the memory port treats a dropped `mem_ren` as a cancel. A late `mem_rvalid` while not in REQ is ignored.
- **New request during a lock:** a requester whose `req_ren` rises while another holds the lock stays stalled until the lock is released and it wins arbitration.

## Timing
- **Reset values:** state IDLE, `owner`=0, `rr_ptr`=0, `req_rdata`=0, `mem_ren`=0, `busy`=0, `lock_timeout`=0, lock counter 0. `req_stall` follows `req_ren` combinationally.
- **Per-access timeline:**
  - Request seen in IDLE at cycle t.
  - `mem_ren` high at t+1.
  - `mem_rvalid` at t+1+L, where L≥0 (same-cycle response allowed).
  - Stall low at t+2+L.
  - Next-level `mem_ren` at t+3+L.
- **Handover:** owner drops `req_ren` at cycle r (the first REQ after RESP). IDLE at r+1; the next winner's `mem_ren` at r+2.
- **Back-to-back accesses:** within one lock there is one bubble cycle (RESP) per level.
- **Fairness:** a continuously requesting requester waits at most N_REQ-1 walks.

## Configuration
`ARB_LOCK_TIMEOUT_EN`
- **Defined:**
  - The counter clears at grant and increments every non-IDLE cycle.
  - In RESP with counter ≥ `LOCK_MAX-1`, the next state is IDLE instead of REQ, and `lock_timeout` pulses for one cycle.
  - The released owner re-arbitrates normally.
- **Undefined:** no counter is built, `lock_timeout` is tied to 0, and the lock lasts until the owner drops `req_ren` or `flush` is asserted.

## Structure
- **Package `arb_pkg`:** `arb_state_t` enum (IDLE=0, REQ=1, RESP=2, 2-bit) and the default-value constant `ARB_LOCK_MAX_DEFAULT`=64.
- **Sub-module `rr_picker`:** combinational round-robin picker with inputs `req[N_REQ]` and `ptr`, and outputs `gnt_idx` and `gnt_valid`. It contains no state; `rr_ptr` lives in the arbiter.

## Test plan
- **Single 3-level walk:** req0 holds `ren`; memory L=2 returns 0x11, 0x22, 0x33 → `req_rdata` shows each value with `req_stall[0]`=0 for exactly 1 cycle each, and 3 `mem_ren` bursts at req0's addresses.
- **Contention:** req0 and req1 both assert `ren` from reset → req0 is granted first; req1 is stalled throughout req0's walk and is granted 2 cycles after req0 drops `ren`.
- **Round-robin:** both requesters request continuously for 4 walks → grant order 0,1,0,1.
- **Mid-access flush:** `flush` is asserted in REQ while waiting for `mem_rvalid` → IDLE next cycle, `mem_ren`=0, late `mem_rvalid` ignored, `req_rdata` unchanged.
- **Reset mid-walk:** `rst`=0 for one cycle during RESP → all registers return to reset values; a fresh grant restarts from req0.
- **Lock timeout (`ARB_LOCK_TIMEOUT_EN`, `LOCK_MAX`=8):** req0 never drops `ren`, L=1, req1 waiting → `lock_timeout` pulses once, and req1 is granted the following IDLE cycle.
